// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: reset/NOP defaults,
// the IF/ID bundle and the fault FSM state encoding.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  function automatic if_id_t if_id_bubble(input logic [31:0] nop_word);
    if_id_t b;
    b.instruction = nop_word;
    b.pc_plus4    = 32'h0000_0000;
    b.valid       = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush injects a bubble, load captures a new
// fetch, otherwise the contents hold.
module if_id_register
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  logic   i_flush,
  input  if_id_t i_data,
  output if_id_t o_data
);

  if_id_t r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= if_id_bubble(NOP_WORD);
    end else if (i_flush) begin
      r_data <= if_id_bubble(NOP_WORD);
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC register, next-PC selection, PC+4 adder and IF/ID register.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault
);

  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic        w_load;
  logic        w_flush;
  if_id_t      w_if_id_d;
  if_id_t      w_if_id_q;

  // Single 32-bit adder; the carry-out is dropped so 0xFFFF_FFFC wraps to 0.
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = redirect_target & 32'hFFFF_FFFC;
  assign w_if_id_d  = '{instruction: imem_instruction, pc_plus4: w_pc_plus4, valid: 1'b1};

`ifdef FETCH_MISALIGN_CHECK_EN
  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic         w_misaligned;

  assign w_misaligned = (redirect_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_next_pc    = r_pc;
    w_load       = 1'b0;
    w_flush      = 1'b0;
    if (r_state == ST_FAULT) begin
      w_flush = 1'b1;
    end else if (redirect) begin
      w_flush = 1'b1;
      if (w_misaligned) w_state_next = ST_FAULT;
      else              w_next_pc    = w_target;
    end else if (!stall) begin
      w_next_pc = w_pc_plus4;
      w_load    = 1'b1;
    end
  end

  assign fetch_fault = (r_state == ST_FAULT);
`else
  always_comb begin
    w_next_pc = r_pc;
    w_load    = 1'b0;
    w_flush   = 1'b0;
    if (redirect) begin
      w_next_pc = w_target;
      w_flush   = 1'b1;
    end else if (!stall) begin
      w_next_pc = w_pc_plus4;
      w_load    = 1'b1;
    end
  end

  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pc <= RESET_PC;
    else        r_pc <= w_next_pc;
  end

  if_id_register #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_data  (w_if_id_d),
    .o_data  (w_if_id_q)
  );

  assign imem_address      = r_pc;
  assign if_id_instruction = w_if_id_q.instruction;
  assign if_id_pc_plus4    = w_if_id_q.pc_plus4;
  assign if_id_valid       = w_if_id_q.valid;

endmodule
